// File: rtl/obi_arb_scheduler.sv
// obi_arb_scheduler: arbitration and response-ordering core for an N:1 OBI mux.
// Round-robin arbitration with lock-in, a global outstanding limit (order FIFO depth)
// and, when OBI_ARB_SCHED_QUOTA_EN is defined, a per-port outstanding limit.
// The order FIFO records which port owns each outstanding transaction so the
// datapath can steer R-channel responses via rsp_idx_o.
module obi_arb_scheduler #(
  parameter  int unsigned NumPorts        = 4,
  parameter  int unsigned NumMaxTrans     = 4,
  parameter  int unsigned MaxTransPerPort = 2,
  localparam int unsigned IdxWidth        = $clog2(NumPorts)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] req_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [IdxWidth-1:0] sel_idx_o,
  output logic                mst_req_o,
  input  logic                mst_gnt_i,
  input  logic                mst_rvalid_i,
  input  logic                mst_rready_i,
  output logic [IdxWidth-1:0] rsp_idx_o,
  output logic                empty_o,
  output logic                err_o
);

  localparam int unsigned         PtrWidth  = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned         CntWidth  = $clog2(NumMaxTrans + 1);
  localparam logic [IdxWidth:0]   NumPortsW = (IdxWidth + 1)'(NumPorts);
  localparam logic [IdxWidth-1:0] LastPort  = IdxWidth'(NumPorts - 1);
  localparam logic [PtrWidth-1:0] LastSlot  = PtrWidth'(NumMaxTrans - 1);
  localparam logic [CntWidth-1:0] FullCount = CntWidth'(NumMaxTrans);

  typedef enum logic {
    LockIdle,
    LockHeld
  } lock_e;

  lock_e               lock_q, lock_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [IdxWidth-1:0] fifo_q [NumMaxTrans];
  logic [PtrWidth-1:0] wptr_q, wptr_d;
  logic [PtrWidth-1:0] rptr_q, rptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                err_q, err_d;

  logic [NumPorts-1:0] eligible;
  logic [IdxWidth-1:0] rr_idx;
  logic                rr_found;
  logic [IdxWidth:0]   cand;
  logic [IdxWidth-1:0] sel;
  logic [IdxWidth-1:0] head;
  logic                locked;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop_err;
  logic                rsp_fire;
  logic                push;
  logic                pop;

`ifdef OBI_ARB_SCHED_QUOTA_EN
  localparam int unsigned           QuotaWidth = $clog2(MaxTransPerPort + 1);
  localparam logic [QuotaWidth-1:0] QuotaMax   = QuotaWidth'(MaxTransPerPort);

  logic [QuotaWidth-1:0] cnt_q [NumPorts];
  logic [QuotaWidth-1:0] cnt_d [NumPorts];

  // A port is eligible only while it is below its outstanding quota
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      eligible[i] = req_i[i] && (cnt_q[i] < QuotaMax);
    end
  end

  // Per-port outstanding counters; grant and response to the same port cancel out
  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({push && (sel == IdxWidth'(i)), pop && (head == IdxWidth'(i))})
        2'b10:   cnt_d[i] = cnt_q[i] + QuotaWidth'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - QuotaWidth'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Per-port counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without quotas every requesting port is eligible
  always_comb begin
    eligible = req_i;
  end
`endif

  // Round-robin search upward from the pointer, wrapping modulo NumPorts
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned off = 0; off < NumPorts; off++) begin
      cand = {1'b0, rr_q} + (IdxWidth + 1)'(off);
      if (cand >= NumPortsW) begin
        cand = cand - NumPortsW;
      end
      if (!rr_found && eligible[cand[IdxWidth-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[IdxWidth-1:0];
      end
    end
  end

  // A-channel request/grant, response steering and error detection
  always_comb begin
    locked     = (lock_q == LockHeld);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FullCount);
    head       = fifo_q[rptr_q];
    drop_err   = locked && !req_i[lock_idx_q];
    sel        = locked ? lock_idx_q : rr_idx;
    // A locked port that withdraws its request must not be handshaked; rst_ni
    // keeps the outputs quiet while reset is held
    mst_req_o  = rst_ni && !fifo_full && (locked ? !drop_err : rr_found);
    push       = mst_req_o && mst_gnt_i;
    rsp_fire   = mst_rvalid_i && mst_rready_i;
    pop        = rsp_fire && !fifo_empty;
    gnt_o      = '0;
    if (push) begin
      gnt_o[sel] = 1'b1;
    end
    sel_idx_o  = rst_ni ? sel : '0;
    rsp_idx_o  = fifo_empty ? '0 : head;
    empty_o    = fifo_empty;
    err_d      = drop_err || (rsp_fire && fifo_empty);
    err_o      = err_q;
  end

  // Lock FSM next state, RR pointer and FIFO bookkeeping
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    case (lock_q)
      LockIdle: begin
        if (mst_req_o && !mst_gnt_i) begin
          lock_d     = LockHeld;
          lock_idx_d = sel;
        end
      end
      LockHeld: begin
        if (drop_err || push) begin
          lock_d = LockIdle;
        end
      end
      default: lock_d = LockIdle;
    endcase

    rr_d = rr_q;
    if (push) begin
      rr_d = (sel == LastPort) ? '0 : sel + IdxWidth'(1);
    end

    wptr_d = wptr_q;
    if (push) begin
      wptr_d = (wptr_q == LastSlot) ? '0 : wptr_q + PtrWidth'(1);
    end

    rptr_d = rptr_q;
    if (pop) begin
      rptr_d = (rptr_q == LastSlot) ? '0 : rptr_q + PtrWidth'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= LockIdle;
      lock_idx_q <= '0;
      rr_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  // Order FIFO storage: one entry per granted transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumMaxTrans; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wptr_q] <= sel;
    end
  end

endmodule
